regfile_mp: RTL

- Parametrised multi-port integer register file. Successor to the single-write, two-read file in the CPU decode/writeback path.
- Adds configurable width, depth and read-port count, plus two write ports with fixed priority.
- Adds a per-register pending scoreboard for hazard detection and a sequenced zero-clear engine, so the storage array never needs a parallel reset and maps to RAM.

---
 rtl/regfile_mp.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//   - two write ports (w1 has priority over w0 on an address collision)
//   - NRD combinational read ports, register 0 hard-wired to zero
//   - per-register pending scoreboard for hazard detection
//   - sequenced zero-clear engine, so the array has no parallel reset and can map to RAM
// Optional build macro: REGFILE_MP_BYPASS_EN forwards same-cycle write data
// and scoreboard clears onto the read ports.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)   // derived, leave at default
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr_req,
    output logic                init_busy,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend,
    input  logic                w0_en,
    input  logic [AW-1:0]       w0_addr,
    input  logic [XLEN-1:0]     w0_data,
    input  logic                w1_en,
    input  logic [AW-1:0]       w1_addr,
    input  logic [XLEN-1:0]     w1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr
);

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;

    logic busy, wr_ok, w0_act, w1_act, iss_act;

    // Outputs are forced quiet while reset is held or the clear engine runs.
    assign busy      = !rstn || (state_q == CLEAR);
    assign init_busy = busy;

    // A runtime clear request drops any write or issue presented in the same cycle.
    assign wr_ok   = (state_q == RUN) && !clr_req;
    assign w0_act  = wr_ok && w0_en  && (w0_addr  != '0);
    assign w1_act  = wr_ok && w1_en  && (w1_addr  != '0);
    assign iss_act = wr_ok && iss_en && (iss_addr != '0);

    // Next-state logic for the clear sequencer.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred,
        // and comb logic uses blocking '=' while clocked state uses '<='.
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLEAR: begin
                if (idx_q == AW'(NREGS - 1)) state_d = RUN;
                else                         idx_d   = idx_q + AW'(1);
            end
            RUN: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = AW'(1);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Sequencer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= CLEAR;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Scoreboard update: writes clear, issue sets afterwards so a new producer wins.
    always_comb begin
        pend_d = pend_q;
        if (state_q == RUN) begin
            if (clr_req) begin
                pend_d = '0;
            end else begin
                if (w0_act)  pend_d[w0_addr]  = 1'b0;
                if (w1_act)  pend_d[w1_addr]  = 1'b0;
                if (iss_act) pend_d[iss_addr] = 1'b1;
            end
        end
    end

    // Scoreboard register; small enough to reset in parallel.
    always_ff @(posedge clk) begin
        if (!rstn) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    // Storage array: zero-fill from the sequencer, otherwise the two write ports.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; the clear engine zeroes it
        // one entry per cycle so it can be implemented as RAM.
        if (rstn) begin
            if (state_q == CLEAR) begin
                regs[idx_q] <= '0;
            end else begin
                if (w0_act) regs[w0_addr] <= w0_data;
                if (w1_act) regs[w1_addr] <= w1_data;   // later assignment wins on collision
            end
        end
    end

    // Read ports.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] data_k;
        logic            pend_k;

        assign a = rd_addr[k*AW +: AW];

`ifdef REGFILE_MP_BYPASS_EN
        // Array read with same-cycle forwarding of write data and scoreboard clears.
        always_comb begin
            data_k = regs[a];
            pend_k = pend_q[a];
            if (w1_act && (w1_addr == a))      data_k = w1_data;
            else if (w0_act && (w0_addr == a)) data_k = w0_data;
            if (((w0_act && (w0_addr == a)) || (w1_act && (w1_addr == a))) &&
                !(iss_act && (iss_addr == a)))
                pend_k = 1'b0;
        end
`else
        // Plain array read; a same-cycle write shows up after the edge.
        always_comb begin
            data_k = regs[a];
            pend_k = pend_q[a];
        end
`endif

        assign rd_data[k*XLEN +: XLEN] = (busy || (a == '0)) ? '0 : data_k;
        assign rd_pend[k]              = !busy && (a != '0) && pend_k;
    end

endmodule
